hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central stall/flush and D-stage forwarding controller for the 5-stage MIPS pipeline.
- Each cycle it compares the D-stage instruction's register uses (Rs/Rt with TUseRs/TUseRt) against a shadow scoreboard of the in-flight E/M/W producers (dest, TNew).
- It owns the multi-cycle mult/div busy counter.
- Its outputs drive the F/D register hold (Stall) and the E-register bubble insert (FlushE).

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E
- DIV_CYCLES, 10, busy cycles after a div/divu enters E
- TW, 3, width of TUse/TNew fields

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- D_Rs  in  5  D-stage rs index
- D_Rt  in  5  D-stage rt index
- D_TUseRs  in  TW  cycles after D until rs is needed (7 = unused)
- D_TUseRt  in  TW  same for rt
- D_Dst  in  5  D-stage destination register (0 = none)
- D_RegWrite  in  1  D-stage instruction writes GPR
- D_TNew  in  TW  cycles after entering E until the result is forwardable
- D_IsMD  in  1  D instruction uses HI/LO or the mult/div unit
- D_MDStart  in  1  D instruction starts mult/div
- D_MDIsDiv  in  1  qualifies D_MDStart: 1 = div, 0 = mult
- Stall  out  1  hold PC and the D register
- FlushE  out  1  load a bubble into the E register
- FwdRsD  out  2  D-stage rs source: 0 = RF, 1 = E, 2 = M, 3 = W
- FwdRtD  out  2  same for rt
- MDBusy  out  1  mult/div counter nonzero

Behaviour:
- Scoreboard: three entries {valid, dst[4:0], tnew[TW-1:0]} for E, M and W. An entry is valid only if RegWrite=1 and dst!=0.
- Scoreboard update on each posedge, when not Reset:
  - E <= Stall ? bubble (valid=0) : {D_RegWrite && D_Dst!=0, D_Dst, D_TNew}
  - M <= E with tnew saturating-decremented (0 stays 0)
  - W <= M with tnew saturating-decremented
- Producer match for rs: the nearest valid stage (E before M before W) whose dst equals D_Rs. A younger match shadows older ones. Rt is handled the same way.
- stall_rs = D_Rs!=0 && a match exists && match.tnew > D_TUseRs. stall_rt is analogous.
- Forwarding:
  - FwdRsD = code of the matched stage if match.tnew==0, else 0.
  - When D_Rs==0 or there is no match, FwdRsD is 0. FwdRtD is analogous.
  - Forwarding here covers D-stage consumers only (branch compare, jr). E-stage forwarding is out of scope.
- Mult/div counter md_cnt (width clog2(DIV_CYCLES+1)):
  - When Reset: md_cnt <= 0.
  - Else if D_MDStart && !Stall: md_cnt <= D_MDIsDiv ? DIV_CYCLES : MULT_CYCLES. This loads at the edge that moves the instruction into E.
  - Else if md_cnt!=0: md_cnt <= md_cnt-1.
- MDBusy = (md_cnt!=0).
- stall_md = D_IsMD && md_cnt!=0. A start issued at edge N blocks any MD instruction in D for the following MULT_CYCLES/DIV_CYCLES cycles.
- Stall = stall_rs | stall_rt | stall_md. FlushE = Stall.
- Stall, FlushE and the Fwd outputs are combinational from the D inputs and registered state. They carry no extra latency.
- Reset:
  - All scoreboard entries become invalid, so at reset Stall=0, FlushE=0, FwdRsD=FwdRtD=0 and MDBusy=0.
  - A reset mid mult/div aborts the count immediately.
- Boundary rules:
  - $0 never stalls and never forwards.
  - TUse=7 never stalls.
  - TNew=0 in E (e.g. lui, jal) forwards from E with no stall.
  - A simultaneous rs and rt hazard produces a single Stall.
  - A D_MDStart while md_cnt!=0 cannot occur, because stall_md blocks it. Any D_MDStart that does arrive while Stall=1 is ignored.

Decomposition:
- Shared header/package: CTRL_LEN, the control-field bit positions (TUseRs 16:14, TUseRt 13:11, TNew 10:8), the FWD_RF/E/M/W codes, and the TUSE_NONE=7 constant.
- One natural sub-module: hazard_sb_stage, a single scoreboard entry with a saturating tnew decrement, instantiated for E, M and W.
- The match/priority logic stays in the top module.

Test Plan:
- Load-use:
  - Stimulus: lw to $8 in D (TNew=2, RegWrite=1), then add with Rs=8, TUseRs=1.
  - Response: Stall=FlushE=1 for exactly 1 cycle, then 0. FwdRsD=0 throughout.
- Branch after ALU:
  - Stimulus: addu to $3 (TNew=1), then beq with Rs=3, TUseRs=0.
  - Response: 1-cycle stall, then FwdRsD=2 (M) with Stall=0.
- Shadowing and $0:
  - Stimulus: ori $5 (TNew=1) and lui $5 (TNew=0) issued back-to-back, then beq with Rs=5, TUseRs=0.
  - Response: matches E (lui), FwdRsD=1, no stall.
  - Stimulus: Rs=0 with an E entry dst=0.
  - Response: FwdRsD=0, Stall=0.
- Mult/div busy:
  - Stimulus: issue div (D_MDStart=1, D_MDIsDiv=1), then mfhi (D_IsMD=1).
  - Response: MDBusy=1 and Stall=1 for 10 cycles, released on cycle 11. With mult instead, the release comes after 5 cycles.
- Reset mid-operation:
  - Stimulus: assert Reset at md_cnt=4 with the E entry valid.
  - Response: next cycle MDBusy=0, Stall=0, FwdRsD=FwdRtD=0, and all entries are invalid.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller:
// control-word field positions and forwarding source codes.
package hazard_ctrl_pkg;

  localparam int CTRL_LEN = 17;

  localparam int TUSE_RS_HI = 16;
  localparam int TUSE_RS_LO = 14;
  localparam int TUSE_RT_HI = 13;
  localparam int TUSE_RT_LO = 11;
  localparam int TNEW_HI    = 10;
  localparam int TNEW_LO    = 8;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [2:0] TUSE_NONE = 3'd7;

endpackage

// File: rtl/hazard_sb_stage.sv
// One shadow-scoreboard entry (valid, dst, tnew).
// DEC selects a saturating tnew decrement on load.
module hazard_sb_stage #(
  parameter int TW  = 3,
  parameter bit DEC = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          i_valid,
  input  logic [4:0]    i_dst,
  input  logic [TW-1:0] i_tnew,
  output logic          o_valid,
  output logic [4:0]    o_dst,
  output logic [TW-1:0] o_tnew
);

  logic          r_valid;
  logic [4:0]    r_dst;
  logic [TW-1:0] r_tnew;
  logic [TW-1:0] w_tnew;

  always_comb begin
    w_tnew = i_tnew;
    if (DEC && (i_tnew != '0))
      w_tnew = i_tnew - TW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_dst   <= '0;
      r_tnew  <= '0;
    end else begin
      r_valid <= i_valid;
      r_dst   <= i_dst;
      r_tnew  <= w_tnew;
    end
  end

  assign o_valid = r_valid;
  assign o_dst   = r_dst;
  assign o_tnew  = r_tnew;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush and D-stage forwarding control for the
// 5-stage pipeline, including the mult/div busy counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int TW          = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [4:0]    D_Rs,
  input  logic [4:0]    D_Rt,
  input  logic [TW-1:0] D_TUseRs,
  input  logic [TW-1:0] D_TUseRt,
  input  logic [4:0]    D_Dst,
  input  logic          D_RegWrite,
  input  logic [TW-1:0] D_TNew,
  input  logic          D_IsMD,
  input  logic          D_MDStart,
  input  logic          D_MDIsDiv,
  output logic          Stall,
  output logic          FlushE,
  output logic [1:0]    FwdRsD,
  output logic [1:0]    FwdRtD,
  output logic          MDBusy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic          w_stall;
  logic          w_e_valid;
  logic [2:0]    w_v;
  logic [4:0]    w_d [3];
  logic [TW-1:0] w_t [3];

  logic          w_hit_rs;
  logic          w_hit_rt;
  logic [1:0]    w_src_rs;
  logic [1:0]    w_src_rt;
  logic [TW-1:0] w_tn_rs;
  logic [TW-1:0] w_tn_rt;
  logic          w_stall_rs;
  logic          w_stall_rt;
  logic          w_stall_md;

  logic [CW-1:0] r_md_cnt;

  // A stalled D instruction enters E as a bubble.
  assign w_e_valid = !w_stall && D_RegWrite
                   && (D_Dst != 5'd0);

  hazard_sb_stage #(.TW(TW), .DEC(1'b0)) u_sb_e (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_valid (w_e_valid),
    .i_dst   (D_Dst),
    .i_tnew  (D_TNew),
    .o_valid (w_v[0]),
    .o_dst   (w_d[0]),
    .o_tnew  (w_t[0])
  );

  hazard_sb_stage #(.TW(TW), .DEC(1'b1)) u_sb_m (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_valid (w_v[0]),
    .i_dst   (w_d[0]),
    .i_tnew  (w_t[0]),
    .o_valid (w_v[1]),
    .o_dst   (w_d[1]),
    .o_tnew  (w_t[1])
  );

  hazard_sb_stage #(.TW(TW), .DEC(1'b1)) u_sb_w (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_valid (w_v[1]),
    .i_dst   (w_d[1]),
    .i_tnew  (w_t[1]),
    .o_valid (w_v[2]),
    .o_dst   (w_d[2]),
    .o_tnew  (w_t[2])
  );

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_hit_rs = 1'b0;
    w_hit_rt = 1'b0;
    w_src_rs = FWD_RF;
    w_src_rt = FWD_RF;
    w_tn_rs  = '0;
    w_tn_rt  = '0;
    for (int i = 2; i >= 0; i--) begin
      if (w_v[i] && (D_Rs != 5'd0)
          && (w_d[i] == D_Rs)) begin
        w_hit_rs = 1'b1;
        w_src_rs = FWD_E + 2'(i);
        w_tn_rs  = w_t[i];
      end
      if (w_v[i] && (D_Rt != 5'd0)
          && (w_d[i] == D_Rt)) begin
        w_hit_rt = 1'b1;
        w_src_rt = FWD_E + 2'(i);
        w_tn_rt  = w_t[i];
      end
    end
  end

  assign w_stall_rs = w_hit_rs && (w_tn_rs > D_TUseRs);
  assign w_stall_rt = w_hit_rt && (w_tn_rt > D_TUseRt);
  assign w_stall_md = D_IsMD && (r_md_cnt != '0);
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  always_ff @(posedge Clk) begin
    if (Reset)
      r_md_cnt <= '0;
    else if (D_MDStart && !w_stall)
      r_md_cnt <= D_MDIsDiv ? CW'(DIV_CYCLES)
                            : CW'(MULT_CYCLES);
    else if (r_md_cnt != '0)
      r_md_cnt <= r_md_cnt - CW'(1);
  end

  assign Stall  = w_stall;
  assign FlushE = w_stall;
  assign MDBusy = (r_md_cnt != '0);

  assign FwdRsD = (w_hit_rs && (w_tn_rs == '0))
                ? w_src_rs : FWD_RF;
  assign FwdRtD = (w_hit_rt && (w_tn_rt == '0))
                ? w_src_rt : FWD_RF;

endmodule
